// File: rtl/opl3_timer_if.sv
// opl3_timer_if
// Bus between the OPL3 register-write decoder / host read path and the
// timer bank.
//
// Write side, driven by the decoder:
//   preload_wr    one-hot strobe that latches preload_data into preload[i]
//   preload_data  preload value (regs 0x02/0x03)
//   ctrl_wr       control write strobe (reg 0x04)
//   ctrl_rst      with ctrl_wr: clear all flags; start/mask fields ignored
//   ctrl_mask     with ctrl_wr and !ctrl_rst: new mask bits
//   ctrl_start    with ctrl_wr and !ctrl_rst: new start bits
//
// Status side, driven by the timer bank:
//   flags         sticky overflow flags
//   irq           OR of the flags, registered
//   timer_tick    one-cycle pulse per timer tick
interface opl3_timer_if #(
    parameter int NUM_TIMERS  = 2,
    parameter int TIMER_WIDTH = 8
);
    logic [NUM_TIMERS-1:0]  preload_wr;
    logic [TIMER_WIDTH-1:0] preload_data;
    logic                   ctrl_wr;
    logic                   ctrl_rst;
    logic [NUM_TIMERS-1:0]  ctrl_mask;
    logic [NUM_TIMERS-1:0]  ctrl_start;
    logic [NUM_TIMERS-1:0]  flags;
    logic                   irq;
    logic [NUM_TIMERS-1:0]  timer_tick;

    modport master (
        output preload_wr, preload_data, ctrl_wr, ctrl_rst, ctrl_mask, ctrl_start,
        input  flags, irq, timer_tick
    );

    modport slave (
        input  preload_wr, preload_data, ctrl_wr, ctrl_rst, ctrl_mask, ctrl_start,
        output flags, irq, timer_tick
    );
endinterface

// File: rtl/opl3_timer_bank.sv
// opl3_timer_bank
// OPL3-style timer block. NUM_TIMERS up-counting timers share one base tick,
// which is generated by a fractional phase accumulator. Timer i ticks once
// every 2^(PRESCALE_SHIFT*i) base ticks. The block implements the reg 0x04
// start / mask / flag-reset semantics and produces sticky overflow flags
// plus an IRQ.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous reset, active low
//   bus      opl3_timer_if slave:
//              preload/ctrl strobes in;
//              flags, irq and timer_tick out
module opl3_timer_bank #(
    parameter int CLK_FREQ       = 24_576_000,
    parameter int BASE_TICK_HZ   = 12_500,
    parameter int NUM_TIMERS     = 2,
    parameter int TIMER_WIDTH    = 8,
    parameter int PRESCALE_SHIFT = 2,
    parameter int ACC_WIDTH      = 24
) (
    input  logic         clk,
    input  logic         reset_n,
    opl3_timer_if.slave  bus
);

    // Rounded accumulator increment: BASE_TICK_HZ * 2^ACC_WIDTH / CLK_FREQ.
    localparam longint INC_FULL =
        ((longint'(BASE_TICK_HZ) << ACC_WIDTH) + longint'(CLK_FREQ / 2)) / longint'(CLK_FREQ);
    localparam logic [ACC_WIDTH-1:0] INC = INC_FULL[ACC_WIDTH-1:0];

    // A single timer needs no prescaler, but a zero-width vector is illegal.
    localparam int PSC_RAW = PRESCALE_SHIFT * (NUM_TIMERS - 1);
    localparam int PSC_W   = (PSC_RAW > 0) ? PSC_RAW : 1;

    if (INC_FULL <= 0 || INC_FULL >= (longint'(1) << (ACC_WIDTH - 1))) begin : g_inc_check
        $error("opl3_timer_bank: accumulator increment out of range");
    end
    if (NUM_TIMERS < 1 || NUM_TIMERS > 4) begin : g_num_check
        $error("opl3_timer_bank: NUM_TIMERS must be 1..4");
    end

    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH:0]     acc_sum;
    logic                   base_tick;
    logic [PSC_W-1:0]       prescaler;
    logic [NUM_TIMERS-1:0]  tick;
    logic [NUM_TIMERS-1:0]  timer_tick_reg;

    logic [TIMER_WIDTH-1:0] counter      [NUM_TIMERS];
    logic [TIMER_WIDTH-1:0] counter_next [NUM_TIMERS];
    logic [TIMER_WIDTH-1:0] preload      [NUM_TIMERS];
    logic [TIMER_WIDTH-1:0] preload_next [NUM_TIMERS];
    logic [NUM_TIMERS-1:0]  start, start_next;
    logic [NUM_TIMERS-1:0]  mask, mask_next;
    logic [NUM_TIMERS-1:0]  flags_reg, flags_next;
    logic [NUM_TIMERS-1:0]  overflow;
    logic                   irq_reg;
    logic                   ctrl_load;
    logic                   flag_clear;

    assign acc_sum = {1'b0, acc} + {1'b0, INC};

    // Base tick is the registered carry out of the accumulator. The prescaler
    // advances on every base tick and wraps naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc            <= '0;
            base_tick      <= 1'b0;
            prescaler      <= '0;
            timer_tick_reg <= '0;
        end else begin
            acc            <= acc_sum[ACC_WIDTH-1:0];
            base_tick      <= acc_sum[ACC_WIDTH];
            timer_tick_reg <= tick;
            if (base_tick) begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    // Timer i ticks on the base tick where the low PRESCALE_SHIFT*i prescaler
    // bits are all ones, so it fires once every 2^(PRESCALE_SHIFT*i) base ticks.
    for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_tick
        localparam int LOW = PRESCALE_SHIFT * g;
        if (LOW == 0) begin : g_base
            assign tick[g] = base_tick;
        end else begin : g_div
            assign tick[g] = base_tick & (&prescaler[LOW-1:0]);
        end
    end

    assign ctrl_load  = bus.ctrl_wr & ~bus.ctrl_rst;
    assign flag_clear = bus.ctrl_wr & bus.ctrl_rst;

    // Next-state logic for the control registers, counters and flags.
    // A start rising edge reloads the counter and takes priority over the
    // tick. An overflow reloads the counter even when masked; only an
    // unmasked overflow sets the flag. The flag set is applied after the
    // ctrl_rst clear so that a simultaneous overflow is never lost.
    always_comb begin
        start_next = start;
        mask_next  = mask;
        flags_next = flag_clear ? '0 : flags_reg;
        overflow   = '0;
        if (ctrl_load) begin
            start_next = bus.ctrl_start;
            mask_next  = bus.ctrl_mask;
        end
        for (int i = 0; i < NUM_TIMERS; i++) begin
            preload_next[i] = bus.preload_wr[i] ? bus.preload_data : preload[i];
            counter_next[i] = counter[i];
            overflow[i]     = start[i] & tick[i] & (counter[i] == '1);
            if (ctrl_load & bus.ctrl_start[i] & ~start[i]) begin
                counter_next[i] = preload[i];
            end else if (start[i] & tick[i]) begin
                counter_next[i] = overflow[i] ? preload[i] : counter[i] + 1'b1;
            end
            if (overflow[i] & ~mask[i]) begin
                flags_next[i] = 1'b1;
            end
        end
    end

    // State registers. irq follows the same next-flags value, so it always
    // agrees with flags after each edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start     <= '0;
            mask      <= '0;
            flags_reg <= '0;
            irq_reg   <= 1'b0;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                counter[i] <= '0;
                preload[i] <= '0;
            end
        end else begin
            start     <= start_next;
            mask      <= mask_next;
            flags_reg <= flags_next;
            irq_reg   <= |flags_next;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                counter[i] <= counter_next[i];
                preload[i] <= preload_next[i];
            end
        end
    end

    assign bus.flags      = flags_reg;
    assign bus.irq        = irq_reg;
    assign bus.timer_tick = timer_tick_reg;

endmodule

// File: tb/tb_opl3_timer_bank.sv
// tb_opl3_timer_bank
// Directed testbench for opl3_timer_bank with the default parameters
// (24.576 MHz clock, 80 us base tick, two 8-bit timers).
//
// Expected timing comes from the nominal increment of 8533. This gives a
// base tick period of 2^24/8533 = 1966.157 clocks, so a single period is
// 1966 or 1967 clocks and ten periods are 19661 or 19662 clocks.
//
// A small accumulator model predicts the exact cycle of each base tick. The
// bench uses it to align a ctrl_rst with an overflow.
module tb_opl3_timer_bank;

    localparam int          NT      = 2;
    localparam int          TW      = 8;
    localparam logic [23:0] INC_EXP = 24'd8533;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    opl3_timer_if #(.NUM_TIMERS(NT), .TIMER_WIDTH(TW)) bus ();

    opl3_timer_bank #(
        .CLK_FREQ      (24_576_000),
        .BASE_TICK_HZ  (12_500),
        .NUM_TIMERS    (NT),
        .TIMER_WIDTH   (TW),
        .PRESCALE_SHIFT(2),
        .ACC_WIDTH     (24)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Reference accumulator. m_base is high during the cycle in which the
    // DUT's registered base tick is high.
    logic [23:0] m_acc;
    logic        m_base;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_acc  <= '0;
            m_base <= 1'b0;
        end else begin
            m_acc  <= m_acc + INC_EXP;
            m_base <= (25'(m_acc) + 25'(INC_EXP)) > 25'h0FF_FFFF;
        end
    end

    int checks = 0;
    int errors = 0;

    // All stimulus tasks are entered and left on a falling clock edge.
    task automatic ctrl_write(input logic r, input logic [NT-1:0] m, input logic [NT-1:0] s);
        bus.ctrl_wr    = 1'b1;
        bus.ctrl_rst   = r;
        bus.ctrl_mask  = m;
        bus.ctrl_start = s;
        @(negedge clk);
        bus.ctrl_wr    = 1'b0;
        bus.ctrl_rst   = 1'b0;
        bus.ctrl_mask  = '0;
        bus.ctrl_start = '0;
    endtask

    task automatic preload_write(input int idx, input logic [TW-1:0] d);
        bus.preload_wr   = NT'(1) << idx;
        bus.preload_data = d;
        @(negedge clk);
        bus.preload_wr   = '0;
    endtask

    task automatic wait_tick0(input string tag);
        int n;
        n = 0;
        checks++;
        do begin
            @(negedge clk);
            n++;
        end while (bus.timer_tick[0] !== 1'b1 && n < 3000);
        if (bus.timer_tick[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s: no timer_tick[0] within %0d cycles", tag, n);
        end
    endtask

    task automatic wait_model_tick(input string tag);
        int n;
        n = 0;
        checks++;
        do begin
            @(negedge clk);
            n++;
        end while (m_base !== 1'b1 && n < 3000);
        if (m_base !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s: model base tick missing after %0d cycles", tag, n);
        end
    endtask

    task automatic test_reset();
        reset_n          = 1'b0;
        bus.preload_wr   = '0;
        bus.preload_data = '0;
        bus.ctrl_wr      = 1'b0;
        bus.ctrl_rst     = 1'b0;
        bus.ctrl_mask    = '0;
        bus.ctrl_start   = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.flags, bus.irq, bus.timer_tick} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got flags=%b irq=%b tick=%b, expected all 0",
                     bus.flags, bus.irq, bus.timer_tick);
        end
        checks++;
        if (dut.counter[0] !== 8'h00 || dut.counter[1] !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_counters: got %h/%h, expected 00/00", dut.counter[0], dut.counter[1]);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_timer0();
        int n;
        int ticks;
        int cyc;
        preload_write(0, 8'hFF);
        wait_tick0("timer0_sync");
        ctrl_write(1'b0, 2'b00, 2'b01);
        n = 0;
        while (bus.flags[0] !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < 1965 || n > 1967) begin
            errors++;
            $display("[TB] FAIL timer0_latency: flag after %0d clk, expected 1966+/-1", n);
        end
        checks++;
        if (bus.irq !== 1'b1 || bus.flags !== 2'b01) begin
            errors++;
            $display("[TB] FAIL timer0_irq: got irq=%b flags=%b, expected 1/01", bus.irq, bus.flags);
        end
        ticks = 0;
        cyc   = 0;
        while (ticks < 10 && cyc < 25000) begin
            @(negedge clk);
            cyc++;
            if (bus.timer_tick[0] === 1'b1) ticks++;
        end
        checks++;
        if (cyc < 19661 || cyc > 19662) begin
            errors++;
            $display("[TB] FAIL base_period: 10 ticks took %0d clk, expected 19661..19662", cyc);
        end
    endtask

    task automatic test_timer1();
        int t1;
        int between;
        int n;
        ctrl_write(1'b0, 2'b00, 2'b00);
        ctrl_write(1'b1, 2'b00, 2'b00);
        checks++;
        if (bus.flags !== 2'b00 || bus.irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flag_clear: got flags=%b irq=%b, expected 00/0", bus.flags, bus.irq);
        end
        preload_write(1, 8'hFE);
        ctrl_write(1'b0, 2'b00, 2'b10);
        checks++;
        if (dut.counter[1] !== 8'hFE) begin
            errors++;
            $display("[TB] FAIL timer1_load: got %h, expected fe", dut.counter[1]);
        end
        t1      = 0;
        between = 0;
        n       = 0;
        while (bus.flags[1] !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
            if (bus.timer_tick[0] === 1'b1 && t1 >= 1) between++;
            if (bus.timer_tick[1] === 1'b1) t1++;
        end
        checks++;
        if (t1 !== 2) begin
            errors++;
            $display("[TB] FAIL timer1_ticks: flag after %0d timer1 ticks, expected 2", t1);
        end
        checks++;
        if (between !== 4) begin
            errors++;
            $display("[TB] FAIL timer1_prescale: %0d base ticks per timer1 tick, expected 4", between);
        end
        checks++;
        if (bus.flags !== 2'b10 || bus.irq !== 1'b1 || dut.counter[1] !== 8'hFE) begin
            errors++;
            $display("[TB] FAIL timer1_flag: got flags=%b irq=%b cnt=%h, expected 10/1/fe",
                     bus.flags, bus.irq, dut.counter[1]);
        end
    endtask

    task automatic test_mask();
        ctrl_write(1'b0, 2'b00, 2'b00);
        ctrl_write(1'b1, 2'b00, 2'b00);
        preload_write(0, 8'hFF);
        ctrl_write(1'b0, 2'b01, 2'b01);
        wait_tick0("mask_tick");
        checks++;
        if (bus.flags !== 2'b00 || bus.irq !== 1'b0 || dut.counter[0] !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL mask_suppress: got flags=%b irq=%b cnt=%h, expected 00/0/ff",
                     bus.flags, bus.irq, dut.counter[0]);
        end
        ctrl_write(1'b0, 2'b00, 2'b01);
        wait_tick0("unmask_tick");
        checks++;
        if (bus.flags !== 2'b01 || bus.irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL unmask_flag: got flags=%b irq=%b, expected 01/1", bus.flags, bus.irq);
        end
        ctrl_write(1'b0, 2'b01, 2'b01);
        checks++;
        if (bus.flags !== 2'b01) begin
            errors++;
            $display("[TB] FAIL mask_keeps_flag: got flags=%b, expected 01", bus.flags);
        end
        ctrl_write(1'b0, 2'b00, 2'b01);
    endtask

    task automatic test_simultaneous();
        ctrl_write(1'b1, 2'b00, 2'b00);
        wait_model_tick("simul_align");
        ctrl_write(1'b1, 2'b00, 2'b00);
        checks++;
        if (bus.flags !== 2'b01 || bus.irq !== 1'b1 || bus.timer_tick[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_vs_overflow: got flags=%b irq=%b tick=%b, expected 01/1/1",
                     bus.flags, bus.irq, bus.timer_tick[0]);
        end
        wait_model_tick("late_align");
        @(negedge clk);
        ctrl_write(1'b1, 2'b00, 2'b00);
        checks++;
        if (bus.flags !== 2'b00 || bus.irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_after_overflow: got flags=%b irq=%b, expected 00/0", bus.flags, bus.irq);
        end
    endtask

    task automatic test_stop_restart();
        int ticks;
        int n;
        ctrl_write(1'b0, 2'b00, 2'b00);
        ctrl_write(1'b1, 2'b00, 2'b00);
        preload_write(0, 8'h7E);
        ctrl_write(1'b0, 2'b00, 2'b01);
        wait_tick0("stop_count1");
        wait_tick0("stop_count2");
        ctrl_write(1'b0, 2'b00, 2'b00);
        checks++;
        if (dut.counter[0] !== 8'h80) begin
            errors++;
            $display("[TB] FAIL stop_count: got %h, expected 80", dut.counter[0]);
        end
        ticks = 0;
        n     = 0;
        while (ticks < 10 && n < 25000) begin
            @(negedge clk);
            n++;
            if (bus.timer_tick[0] === 1'b1) ticks++;
        end
        checks++;
        if (dut.counter[0] !== 8'h80 || bus.flags !== 2'b00 || ticks !== 10) begin
            errors++;
            $display("[TB] FAIL stop_hold: got cnt=%h flags=%b ticks=%0d, expected 80/00/10",
                     dut.counter[0], bus.flags, ticks);
        end
        preload_write(0, 8'h10);
        ctrl_write(1'b0, 2'b00, 2'b01);
        checks++;
        if (dut.counter[0] !== 8'h10) begin
            errors++;
            $display("[TB] FAIL restart_load: got %h, expected 10", dut.counter[0]);
        end
        wait_tick0("restart_tick");
        preload_write(0, 8'h40);
        ctrl_write(1'b0, 2'b00, 2'b01);
        checks++;
        if (dut.counter[0] !== 8'h11) begin
            errors++;
            $display("[TB] FAIL rewrite_no_reload: got %h, expected 11", dut.counter[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        ctrl_write(1'b0, 2'b00, 2'b00);
        preload_write(0, 8'hFF);
        ctrl_write(1'b0, 2'b00, 2'b01);
        wait_tick0("pre_reset_tick");
        checks++;
        if (bus.flags !== 2'b01) begin
            errors++;
            $display("[TB] FAIL pre_reset_flag: got %b, expected 01", bus.flags);
        end
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.flags, bus.irq, bus.timer_tick} !== 5'b0 || dut.counter[0] !== 8'h00) begin
            errors++;
            $display("[TB] FAIL mid_reset: got flags=%b irq=%b tick=%b cnt=%h, expected all 0",
                     bus.flags, bus.irq, bus.timer_tick, dut.counter[0]);
        end
        reset_n = 1'b1;
        wait_tick0("post_reset1");
        wait_tick0("post_reset2");
        checks++;
        if (bus.flags !== 2'b00 || bus.irq !== 1'b0 || dut.counter[0] !== 8'h00) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: got flags=%b irq=%b cnt=%h, expected 00/0/00",
                     bus.flags, bus.irq, dut.counter[0]);
        end
    endtask

    initial begin
        $display("[TB] opl3_timer_bank directed test start");
        @(negedge clk);
        test_reset();
        test_timer0();
        test_timer1();
        test_mask();
        test_simultaneous();
        test_stop_restart();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
